// File: rtl/dcache_fill_fsm.sv
// D-cache miss handler: fetches a 16-byte block as eight word reads.
// Optional macro DCACHE_CWF_EN starts the fill at the missed word.
module dcache_fill_fsm #(
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] fill_address,
  output logic        fill_done,
  output logic        crit_word
);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [11:0] blk_addr;
  logic [11:0] blk_addr_d;
  logic [2:0]  start_idx;
  logic [2:0]  start_idx_d;
  logic [3:0]  req_cnt;
  logic [3:0]  req_cnt_d;
  logic [3:0]  rcv_cnt;
  logic [3:0]  rcv_cnt_d;
  logic [2:0]  miss_idx;
  logic        unused_ok;

`ifdef DCACHE_CWF_EN
  assign miss_idx = miss_address[3:1];
`else
  assign miss_idx = 3'd0;
`endif

  // Data words go straight to the array; the FSM only sequences them.
  assign unused_ok = ^{memory_data, miss_address[3:0]};

  // State and fill bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      blk_addr  <= '0;
      start_idx <= '0;
      req_cnt   <= '0;
      rcv_cnt   <= '0;
    end else begin
      state     <= state_d;
      blk_addr  <= blk_addr_d;
      start_idx <= start_idx_d;
      req_cnt   <= req_cnt_d;
      rcv_cnt   <= rcv_cnt_d;
    end
  end

  // Next state, counters and per-cycle outputs.
  always_comb begin
    state_d          = state;
    blk_addr_d       = blk_addr;
    start_idx_d      = start_idx;
    req_cnt_d        = req_cnt;
    rcv_cnt_d        = rcv_cnt;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_address     = '0;
    fill_done        = 1'b0;
    crit_word        = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_detected) begin
          blk_addr_d  = miss_address[15:4];
          start_idx_d = miss_idx;
          req_cnt_d   = '0;
          rcv_cnt_d   = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        fsm_busy       = 1'b1;
        mem_en         = (req_cnt < 4'(WORDS));
        memory_address = {blk_addr,
                          start_idx + req_cnt[2:0],
                          1'b0};
        fill_address   = {blk_addr,
                          start_idx + rcv_cnt[2:0],
                          1'b0};
        if (mem_en) begin
          req_cnt_d = req_cnt + 4'd1;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          crit_word        = (rcv_cnt == 4'd0);
          rcv_cnt_d        = rcv_cnt + 4'd1;
          if (rcv_cnt == 4'(WORDS - 1)) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Bench for dcache_fill_fsm: directed scenarios then random fills
// against a queue-based memory and a block-order reference model.
`timescale 1ns/1ps
module tb_dcache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] fill_address;
  logic        fill_done;
  logic        crit_word;

  dcache_fill_fsm #(.WORDS(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_address      (fill_address),
    .fill_done         (fill_done),
    .crit_word         (crit_word)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: a fill is "busy", has a base, a start word,
  // and counts of requests seen and words written
  bit          m_busy = 1'b0;
  logic [15:0] m_base = '0;
  int          m_s = 0;
  int          m_req = 0;
  int          m_wr = 0;

  // memory model: in-order responses after lat cycles
  int          cyc = 0;
  int          lat = 4;
  int          q_t[$];
  logic [15:0] q_a[$];

  int          n_wr = 0;
  int          n_tag = 0;
  int          done_cyc = -1;
  logic [15:0] last_req = '0;
  logic [15:0] last_fill = '0;

`ifdef DCACHE_CWF_EN
  localparam logic [15:0] LAST_1236 = 16'h1234;
`else
  localparam logic [15:0] LAST_1236 = 16'h123E;
`endif

  function automatic logic [15:0] exp_addr(input int k);
    logic [2:0] w;
    w = 3'((m_s + k) % 8);
    return {m_base[15:4], w, 1'b0};
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst,
                      input bit miss,
                      input logic [15:0] ma,
                      input bit stall,
                      input bit stray);
    bit v;
    bit em;
    bit ew;
    bit last;
    rst_n         = !rst;
    miss_detected = miss;
    miss_address  = ma;
    v             = 1'b0;
    memory_data   = '0;
    if (stray) begin
      v           = 1'b1;
      memory_data = 16'hBEEF;
    end else if (q_t.size() > 0 && q_t[0] <= cyc && !stall) begin
      v           = 1'b1;
      memory_data = q_a[0] ^ 16'h5A5A;
      void'(q_t.pop_front());
      void'(q_a.pop_front());
    end
    memory_data_valid = v;
    #3;
    em = m_busy && (m_req < 8);
    chk("mem_en", mem_en, em);
    if (em) begin
      chk("mem_addr", memory_address, exp_addr(m_req));
      q_t.push_back(cyc + lat);
      q_a.push_back(memory_address);
      last_req = memory_address;
      m_req++;
    end else if (!m_busy) begin
      chk("idle_mem_addr", memory_address, 16'h0);
    end
    ew   = m_busy && v;
    last = ew && (m_wr == 7);
    chk("wr_data", write_data_array, ew);
    chk("wr_tag", write_tag_array, last);
    chk("fill_done", fill_done, last);
    chk("crit_word", crit_word, ew && (m_wr == 0));
    chk("busy", fsm_busy, m_busy);
    if (ew) begin
      chk("fill_addr", fill_address, exp_addr(m_wr));
      last_fill = fill_address;
      m_wr++;
    end else if (!m_busy) begin
      chk("idle_fill_addr", fill_address, 16'h0);
    end
    if (write_data_array) n_wr++;
    if (write_tag_array) n_tag++;
    if (fill_done) done_cyc = cyc;
    if (rst) begin
      m_busy = 1'b0;
    end else if (last) begin
      m_busy = 1'b0;
    end else if (!m_busy && miss) begin
      m_busy = 1'b1;
      m_base = ma;
`ifdef DCACHE_CWF_EN
      m_s = int'(ma[3:1]);
`else
      m_s = 0;
`endif
      m_req = 0;
      m_wr  = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int c0;
    int w0;
    int t0;
    logic [15:0] ra;
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data       = '0;
    memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // after reset, then a stray valid in IDLE
    step(0, 0, 16'h0, 0, 0);
    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 0);

    // basic fill at 0x1236, 4-cycle memory
    c0 = cyc; w0 = n_wr; t0 = n_tag;
    step(0, 1, 16'h1236, 0, 0);
    for (int i = 1; i <= 14; i++) step(0, 0, 16'h0, 0, 0);
    chk("basic_done_cyc", 16'(done_cyc - c0), 16'd12);
    chk("basic_writes", 16'(n_wr - w0), 16'd8);
    chk("basic_tags", 16'(n_tag - t0), 16'd1);
    chk("basic_last_req", last_req, LAST_1236);
    chk("basic_last_fill", last_fill, LAST_1236);

    // two-cycle bubble after the third word
    c0 = cyc; w0 = n_wr; t0 = n_tag;
    step(0, 1, 16'h1236, 0, 0);
    for (int i = 1; i <= 16; i++)
      step(0, 0, 16'h0, (i == 8 || i == 9), 0);
    chk("bubble_done_cyc", 16'(done_cyc - c0), 16'd14);
    chk("bubble_writes", 16'(n_wr - w0), 16'd8);
    chk("bubble_tags", 16'(n_tag - t0), 16'd1);

    // reset in cycle 6 of a fill; late valids must be ignored
    w0 = n_wr; t0 = n_tag;
    step(0, 1, 16'h1236, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    for (int i = 7; i <= 14; i++) step(0, 0, 16'h0, 0, 0);
    chk("rst_writes", 16'(n_wr - w0), 16'd2);
    chk("rst_tags", 16'(n_tag - t0), 16'd0);
    chk("rst_q_drained", 16'(q_t.size()), 16'd0);

    // back-to-back: 0x1236 then 0xA000 with miss held high
    c0 = cyc; w0 = n_wr; t0 = n_tag;
    step(0, 1, 16'h1236, 0, 0);
    for (int i = 1; i <= 13; i++) step(0, 1, 16'hA000, 0, 0);
    chk("b2b_first_done", 16'(done_cyc - c0), 16'd12);
    step(0, 0, 16'h0, 0, 0);
    chk("b2b_second_req", last_req, 16'hA000);
    for (int i = 15; i <= 27; i++) step(0, 0, 16'h0, 0, 0);
    chk("b2b_second_done", 16'(done_cyc - c0), 16'd25);
    chk("b2b_writes", 16'(n_wr - w0), 16'd16);
    chk("b2b_tags", 16'(n_tag - t0), 16'd2);

    // random fills: random address, latency, bubbles, stray misses
    for (int f = 0; f < 8; f++) begin
      lat = int'($urandom_range(1, 6));
      ra  = 16'($urandom);
      w0 = n_wr; t0 = n_tag;
      for (int g = int'($urandom_range(0, 2)); g > 0; g--)
        step(0, 0, 16'h0, 0, 0);
      step(0, 1, ra, 0, 0);
      for (int i = 0; i < 80 && m_busy; i++)
        step(0, $urandom_range(0, 1) == 1, 16'($urandom),
             $urandom_range(0, 3) == 0, 0);
      chk("rnd_timeout", fsm_busy, 1'b0);
      chk("rnd_writes", 16'(n_wr - w0), 16'd8);
      chk("rnd_tags", 16'(n_tag - t0), 16'd1);
    end

    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
